// File: rtl/adder_pkg.sv
// Shared types and helpers for the adder family and its result stage.
//   ADDER_WIDTH : datapath width of the combinational adders
//   result_t    : one buffered adder result {carry, ovf, sum}
//   signed_ovf  : two's-complement overflow from the operand/sum sign bits
package adder_pkg;

    localparam int ADDER_WIDTH = 32;

    typedef struct packed {
        logic                   carry;
        logic                   ovf;
        logic [ADDER_WIDTH-1:0] sum;
    } result_t;

    // Overflow happens only when both operands share a sign and the sum's sign differs.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a registered head.
//   clk, rst    : clock, synchronous active-high reset (empties the FIFO)
//   push, pop   : write din / retire head; ignored when full / empty respectively
//   din         : entry written on push
//   full, empty : registered occupancy flags
//   head        : registered oldest entry, all-zero while empty
module sync_fifo #(
    parameter int WIDTH_D = 34,
    parameter int DEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [WIDTH_D-1:0] din,
    output logic               full,
    output logic               empty,
    output logic [WIDTH_D-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH_D-1:0] mem_r [DEPTH];
    logic [AW-1:0]      wr_ptr_r;
    logic [AW-1:0]      rd_ptr_r;
    logic [CW-1:0]      count_r;
    logic [WIDTH_D-1:0] head_r;
    logic               full_r;
    logic               empty_r;

    logic               push_s;
    logic               pop_s;
    logic [CW-1:0]      count_nxt_s;
    logic [CW-1:0]      after_pop_s;
    logic [AW-1:0]      rd_nxt_s;
    logic [WIDTH_D-1:0] head_nxt_s;

    assign push_s = push & ~full_r;
    assign pop_s  = pop & ~empty_r;

    // Next occupancy and next head; the head register is loaded one edge ahead so it is
    // valid right after the push edge. When the FIFO is drained by this pop (or was empty),
    // the only candidate for the new head is the entry being pushed now.
    always_comb begin
        after_pop_s = count_r - {{(CW-1){1'b0}}, pop_s};
        count_nxt_s = after_pop_s + {{(CW-1){1'b0}}, push_s};
        rd_nxt_s    = rd_ptr_r + {{(AW-1){1'b0}}, pop_s};
        if (count_nxt_s == {CW{1'b0}}) begin
            head_nxt_s = {WIDTH_D{1'b0}};
        end else if (after_pop_s == {CW{1'b0}}) begin
            head_nxt_s = din;
        end else begin
            head_nxt_s = mem_r[rd_nxt_s];
        end
    end

    // Pointers, occupancy, flags and head register; pointers wrap naturally (DEPTH is a power of two).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            head_r   <= {WIDTH_D{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, push_s};
            rd_ptr_r <= rd_nxt_s;
            count_r  <= count_nxt_s;
            head_r   <= head_nxt_s;
            full_r   <= (count_nxt_s == CW'(DEPTH));
            empty_r  <= (count_nxt_s == {CW{1'b0}});
        end
    end

    // Storage array; contents need no reset because the head is qualified by occupancy.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= din;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    assign full  = full_r;
    assign empty = empty_r;
    assign head  = head_r;

endmodule

// File: rtl/adder_result_stage.sv
// Registered result stage behind the 32-bit combinational adders.
// Captures {carry, sum} with a derived signed-overflow flag into a small FIFO under a
// valid/ready handshake, and keeps saturating transaction / overflow statistics.
//   clk, rst                       : clock, synchronous active-high reset
//   in_valid_i / in_ready_o        : upstream handshake (ready = FIFO not full)
//   add1_i, add2_i, sum_i, carry_i : operands and the adder's result
//   out_valid_o / out_ready_i      : downstream handshake on the FIFO head
//   sum_o, carry_o, overflow_o     : head result (zero while empty)
//   clr_stats_i                    : synchronous counter clear
//   txn_count_o, ovf_count_o       : saturating accepted / overflowed counts
// WIDTH must equal adder_pkg::ADDER_WIDTH since entries are stored as result_t.
module adder_result_stage
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] add1_i,
    input  logic [WIDTH-1:0] add2_i,
    input  logic [WIDTH-1:0] sum_i,
    input  logic             carry_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             overflow_o,
    input  logic             clr_stats_i,
    output logic [CNT_W-1:0] txn_count_o,
    output logic [CNT_W-1:0] ovf_count_o
);

    logic             push_s;
    logic             pop_s;
    logic             full_s;
    logic             empty_s;
    result_t          entry_s;
    result_t          head_s;
    logic [CNT_W-1:0] txn_cnt_r;
    logic [CNT_W-1:0] ovf_cnt_r;

    // Only the operand sign bits matter for overflow detection.
    logic unused_operand_bits_s;
    assign unused_operand_bits_s = ^{add1_i[WIDTH-2:0], add2_i[WIDTH-2:0]};

    assign in_ready_o  = ~full_s;
    assign out_valid_o = ~empty_s;
    assign push_s      = in_valid_i & ~full_s;
    assign pop_s       = ~empty_s & out_ready_i;

    assign entry_s.carry = carry_i;
    assign entry_s.ovf   = signed_ovf(add1_i[WIDTH-1], add2_i[WIDTH-1], sum_i[WIDTH-1]);
    assign entry_s.sum   = sum_i;

    sync_fifo #(
        .WIDTH_D ($bits(result_t)),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (entry_s),
        .full  (full_s),
        .empty (empty_s),
        .head  (head_s)
    );

    assign sum_o      = head_s.sum;
    assign carry_o    = head_s.carry;
    assign overflow_o = head_s.ovf;

    // Saturating statistics; a clear still counts the push of the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            txn_cnt_r <= {CNT_W{1'b0}};
            ovf_cnt_r <= {CNT_W{1'b0}};
        end else if (clr_stats_i) begin
            txn_cnt_r <= {{(CNT_W-1){1'b0}}, push_s};
            ovf_cnt_r <= {{(CNT_W-1){1'b0}}, push_s & entry_s.ovf};
        end else begin
            if (push_s && (txn_cnt_r != {CNT_W{1'b1}})) begin
                txn_cnt_r <= txn_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                txn_cnt_r <= txn_cnt_r;
            end
            if (push_s && entry_s.ovf && (ovf_cnt_r != {CNT_W{1'b1}})) begin
                ovf_cnt_r <= ovf_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                ovf_cnt_r <= ovf_cnt_r;
            end
        end
    end

    assign txn_count_o = txn_cnt_r;
    assign ovf_count_o = ovf_cnt_r;

endmodule

// File: tb/tb_adder_result_stage.sv
// Directed bench: a default build (CNT_W=16) for data-path / FIFO behaviour and a
// CNT_W=4 build for counter saturation and reset while full.
module tb_adder_result_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Default build signals
    logic        rst_a = 1'b1, in_valid_a = 1'b0, in_ready_a, carry_a = 1'b0;
    logic [31:0] add1_a = 32'd0, add2_a = 32'd0, sum_a = 32'd0;
    logic        out_valid_a, out_ready_a = 1'b0, carry_o_a, ovf_o_a, clr_a = 1'b0;
    logic [31:0] sum_o_a;
    logic [15:0] txn_a, ovfc_a;

    // CNT_W=4 build signals
    logic        rst_b = 1'b1, in_valid_b = 1'b0, in_ready_b, carry_b = 1'b0;
    logic [31:0] add1_b = 32'd0, add2_b = 32'd0, sum_b = 32'd0;
    logic        out_valid_b, out_ready_b = 1'b0, carry_o_b, ovf_o_b, clr_b = 1'b0;
    logic [31:0] sum_o_b;
    logic [3:0]  txn_b, ovfc_b;

    adder_result_stage #(.WIDTH(32), .DEPTH(2), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst_a), .in_valid_i(in_valid_a), .in_ready_o(in_ready_a),
        .add1_i(add1_a), .add2_i(add2_a), .sum_i(sum_a), .carry_i(carry_a),
        .out_valid_o(out_valid_a), .out_ready_i(out_ready_a), .sum_o(sum_o_a),
        .carry_o(carry_o_a), .overflow_o(ovf_o_a), .clr_stats_i(clr_a),
        .txn_count_o(txn_a), .ovf_count_o(ovfc_a)
    );

    adder_result_stage #(.WIDTH(32), .DEPTH(2), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst_b), .in_valid_i(in_valid_b), .in_ready_o(in_ready_b),
        .add1_i(add1_b), .add2_i(add2_b), .sum_i(sum_b), .carry_i(carry_b),
        .out_valid_o(out_valid_b), .out_ready_i(out_ready_b), .sum_o(sum_o_b),
        .carry_o(carry_o_b), .overflow_o(ovf_o_b), .clr_stats_i(clr_b),
        .txn_count_o(txn_b), .ovf_count_o(ovfc_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive default-build inputs at the falling edge, then advance one rising edge
    // and return at the next falling edge where outputs are sampled.
    task automatic step_a(input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] s, input logic c, input logic ordy);
        in_valid_a = v; add1_a = a; add2_a = b; sum_a = s; carry_a = c; out_ready_a = ordy;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step_b(input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] s, input logic c, input logic ordy);
        in_valid_b = v; add1_b = a; add2_b = b; sum_b = s; carry_b = c; out_ready_b = ordy;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // 1. Reset, then idle
        @(negedge clk);
        step_a(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        step_b(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        step_a(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("rst_out_valid", {31'd0, out_valid_a}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready_a},  32'd1);
        chk("rst_txn",       {16'd0, txn_a},       32'd0);
        chk("rst_ovfc",      {16'd0, ovfc_a},      32'd0);
        chk("rst_sum",       sum_o_a,              32'd0);
        chk("rst_carry",     {31'd0, carry_o_a},   32'd0);
        chk("rst_ovf",       {31'd0, ovf_o_a},     32'd0);

        // 2. Positive overflow: 0x7fffffff + 1
        step_a(1'b1, 32'h7fffffff, 32'h00000001, 32'h80000000, 1'b0, 1'b1);
        chk("pos_ovf_valid", {31'd0, out_valid_a}, 32'd1);
        chk("pos_ovf_sum",   sum_o_a,              32'h80000000);
        chk("pos_ovf_flag",  {31'd0, ovf_o_a},     32'd1);
        chk("pos_ovf_count", {16'd0, ovfc_a},      32'd1);
        chk("pos_ovf_txn",   {16'd0, txn_a},       32'd1);

        // 3. Negative overflow with carry, then a non-overflowing mixed-sign add
        step_a(1'b1, 32'h80000000, 32'hffffffff, 32'h7fffffff, 1'b1, 1'b1);
        chk("neg_ovf_sum",   sum_o_a,              32'h7fffffff);
        chk("neg_ovf_flag",  {31'd0, ovf_o_a},     32'd1);
        chk("neg_ovf_carry", {31'd0, carry_o_a},   32'd1);
        chk("neg_ovf_count", {16'd0, ovfc_a},      32'd2);
        step_a(1'b1, 32'd51, 32'hffffffc9, 32'hfffffffc, 1'b0, 1'b1);
        chk("mixed_sum",     sum_o_a,              32'hfffffffc);
        chk("mixed_flag",    {31'd0, ovf_o_a},     32'd0);
        chk("mixed_carry",   {31'd0, carry_o_a},   32'd0);
        chk("mixed_txn",     {16'd0, txn_a},       32'd3);
        chk("mixed_ovfc",    {16'd0, ovfc_a},      32'd2);
        step_a(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        chk("drain_valid",   {31'd0, out_valid_a}, 32'd0);
        chk("drain_zero",    sum_o_a,              32'd0);

        // 4. Stalled consumer: fill, hold third push, then release
        step_a(1'b1, 32'd250, 32'd350, 32'd600, 1'b0, 1'b0);
        chk("stall1_sum",    sum_o_a,              32'd600);
        chk("stall1_ready",  {31'd0, in_ready_a},  32'd1);
        step_a(1'b1, 32'd13, 32'd7, 32'd20, 1'b0, 1'b0);
        chk("stall2_ready",  {31'd0, in_ready_a},  32'd0);
        chk("stall2_head",   sum_o_a,              32'd600);
        step_a(1'b1, 32'hfffffff3, 32'hfffffff9, 32'hffffffec, 1'b1, 1'b0);
        chk("stall3_ready",  {31'd0, in_ready_a},  32'd0);
        chk("stall3_head",   sum_o_a,              32'd600);
        chk("stall3_txn",    {16'd0, txn_a},       32'd5);
        step_a(1'b1, 32'hfffffff3, 32'hfffffff9, 32'hffffffec, 1'b1, 1'b1);
        chk("rel1_sum",      sum_o_a,              32'd20);
        chk("rel1_txn",      {16'd0, txn_a},       32'd5);
        step_a(1'b1, 32'hfffffff3, 32'hfffffff9, 32'hffffffec, 1'b1, 1'b1);
        chk("rel2_sum",      sum_o_a,              32'hffffffec);
        chk("rel2_carry",    {31'd0, carry_o_a},   32'd1);
        chk("rel2_txn",      {16'd0, txn_a},       32'd6);
        step_a(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        chk("rel3_empty",    {31'd0, out_valid_a}, 32'd0);

        // 5. Count held at 1 with simultaneous push and pop
        step_a(1'b1, 32'd100, 32'd0, 32'd100, 1'b0, 1'b0);
        chk("pp_seed",       sum_o_a,              32'd100);
        for (int i = 1; i <= 10; i++) begin
            step_a(1'b1, 32'd100 + 32'(i), 32'd0, 32'd100 + 32'(i), 1'b0, 1'b1);
            chk("pp_sum",    sum_o_a,              32'd100 + 32'(i));
            chk("pp_valid",  {31'd0, out_valid_a}, 32'd1);
            chk("pp_ready",  {31'd0, in_ready_a},  32'd1);
        end
        chk("pp_txn",        {16'd0, txn_a},       32'd17);
        step_a(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        chk("pp_empty",      {31'd0, out_valid_a}, 32'd0);

        // Clear without a push
        clr_a = 1'b1;
        step_a(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        clr_a = 1'b0;
        chk("clr_nopush_txn", {16'd0, txn_a},      32'd0);
        chk("clr_nopush_ovf", {16'd0, ovfc_a},     32'd0);

        // 6. CNT_W=4: saturation, clear with push, reset while full
        for (int i = 0; i < 20; i++) begin
            step_b(1'b1, 32'h7fffffff, 32'h00000001, 32'h80000000, 1'b0, 1'b1);
        end
        chk("sat_txn",       {28'd0, txn_b},       32'd15);
        chk("sat_ovfc",      {28'd0, ovfc_b},      32'd15);
        clr_b = 1'b1;
        step_b(1'b1, 32'd1, 32'd1, 32'd2, 1'b0, 1'b1);
        clr_b = 1'b0;
        chk("clr_push_txn",  {28'd0, txn_b},       32'd1);
        chk("clr_push_ovfc", {28'd0, ovfc_b},      32'd0);
        step_b(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        step_b(1'b1, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0);
        step_b(1'b1, 32'd5, 32'd6, 32'd11, 1'b0, 1'b0);
        chk("full_ready",    {31'd0, in_ready_b},  32'd0);
        chk("full_head",     sum_o_b,              32'd7);
        rst_b = 1'b1;
        step_b(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        rst_b = 1'b0;
        chk("rstfull_valid", {31'd0, out_valid_b}, 32'd0);
        chk("rstfull_ready", {31'd0, in_ready_b},  32'd1);
        chk("rstfull_sum",   sum_o_b,              32'd0);
        chk("rstfull_txn",   {28'd0, txn_b},       32'd0);
        step_b(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        chk("post_rst_valid", {31'd0, out_valid_b}, 32'd0);
        chk("post_rst_sum",   sum_o_b,              32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
